// File: rtl/nvme_pchk_arb_if.sv
// Requester-side bus of the shared parity-check engine: one valid/data/parity
// lane per requester and a one-hot ready returned by the arbiter.
interface nvme_pchk_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 128,
    parameter int PWIDTH  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*WIDTH-1:0]  req_data;
    logic [NUM_REQ*PWIDTH-1:0] req_datap;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_datap,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_datap,
        output req_ready
    );
endinterface

// File: rtl/nvme_pchk_arb.sv
// Round-robin arbitrated byte-group parity checker shared by the AFU data movers,
// with error pulses, sticky per-requester flags, a saturating count and first-error capture.
module nvme_pchk_arb #(
    parameter int NUM_REQ             = 4,
    parameter int WIDTH               = 128,
    parameter int BITS_PER_PARITY_BIT = 8,
    parameter int PWIDTH              = (WIDTH + BITS_PER_PARITY_BIT - 1) / BITS_PER_PARITY_BIT,
    parameter int IDW                 = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    nvme_pchk_arb_if.slave    req_if,
    input  logic              oddpar,
    input  logic              chk_enable,
    input  logic              clr_err,
    output logic              err_valid,
    output logic [IDW-1:0]    err_id,
    output logic [PWIDTH-1:0] err_bits,
    output logic [NUM_REQ-1:0] err_sticky,
    output logic [15:0]       err_count,
    output logic              first_valid,
    output logic [IDW-1:0]    first_id,
    output logic [PWIDTH-1:0] first_bits
);

    localparam logic [15:0]    COUNT_MAX = 16'hFFFF;
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

    // Arbiter state and grant
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     cand;
    logic               xfer;

    // Stage 1: captured beat
    logic               s1_valid_q;
    logic               s1_en_q;
    logic [IDW-1:0]     s1_id_q;
    logic [WIDTH-1:0]   s1_data_q;
    logic [PWIDTH-1:0]  s1_datap_q;

    // Stage 2: parity compare
    logic [PWIDTH-1:0]  gen_par;
    logic [PWIDTH-1:0]  mismatch;
    logic               err_det;

    // Error reporting state
    logic               err_valid_q;
    logic [IDW-1:0]     err_id_q;
    logic [PWIDTH-1:0]  err_bits_q;
    logic [NUM_REQ-1:0] sticky_q, sticky_d;
    logic [15:0]        count_q, count_d;
    logic               first_v_q, first_v_d;
    logic [IDW-1:0]     first_id_q, first_id_d;
    logic [PWIDTH-1:0]  first_bits_q, first_bits_d;

    // Search upward from ptr, wrapping at NUM_REQ; first asserted valid wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        grant    = '0;
        grant_id = '0;
        cand     = '0;
        xfer     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!xfer && req_if.req_valid[cand]) begin
                xfer        = 1'b1;
                grant_id    = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    assign req_if.req_ready = grant;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
    end

    // Generated parity: group k folds data bits [k*bpp +: bpp]; a short last group folds only what exists.
    always_comb begin
        gen_par = {PWIDTH{oddpar}};
        for (int b = 0; b < WIDTH; b++) begin
            gen_par[b / BITS_PER_PARITY_BIT] = gen_par[b / BITS_PER_PARITY_BIT] ^ s1_data_q[b];
        end
    end

    assign mismatch = gen_par ^ s1_datap_q;
    assign err_det  = s1_valid_q & s1_en_q & (|mismatch);

    // Clear is applied first so that an error on the same edge survives it.
    always_comb begin
        sticky_d     = clr_err ? '0 : sticky_q;
        count_d      = clr_err ? '0 : count_q;
        first_v_d    = clr_err ? 1'b0 : first_v_q;
        first_id_d   = clr_err ? '0 : first_id_q;
        first_bits_d = clr_err ? '0 : first_bits_q;
        if (err_det) begin
            sticky_d[s1_id_q] = 1'b1;
            if (count_d != COUNT_MAX) begin
                count_d = count_d + 16'd1;
            end
            if (!first_v_d) begin
                first_v_d    = 1'b1;
                first_id_d   = s1_id_q;
                first_bits_d = mismatch;
            end
        end
    end

    // NOTE: the wide beat payload is deliberately left out of reset; s1_valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (xfer) begin
            s1_data_q  <= req_if.req_data[int'(grant_id)*WIDTH +: WIDTH];
            s1_datap_q <= req_if.req_datap[int'(grant_id)*PWIDTH +: PWIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_en_q      <= 1'b0;
            s1_id_q      <= '0;
            err_valid_q  <= 1'b0;
            err_id_q     <= '0;
            err_bits_q   <= '0;
            sticky_q     <= '0;
            count_q      <= '0;
            first_v_q    <= 1'b0;
            first_id_q   <= '0;
            first_bits_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ptr_q      <= ptr_d;
            s1_valid_q <= xfer;
            if (xfer) begin
                s1_en_q <= chk_enable;
                s1_id_q <= grant_id;
            end
            err_valid_q <= err_det;
            if (err_det) begin
                err_id_q   <= s1_id_q;
                err_bits_q <= mismatch;
            end
            sticky_q     <= sticky_d;
            count_q      <= count_d;
            first_v_q    <= first_v_d;
            first_id_q   <= first_id_d;
            first_bits_q <= first_bits_d;
        end
    end

    assign err_valid   = err_valid_q;
    assign err_id      = err_id_q;
    assign err_bits    = err_bits_q;
    assign err_sticky  = sticky_q;
    assign err_count   = count_q;
    assign first_valid = first_v_q;
    assign first_id    = first_id_q;
    assign first_bits  = first_bits_q;

endmodule

// File: tb/tb_nvme_pchk_arb.sv
// Randomized scoreboard bench for nvme_pchk_arb: the driver predicts grants and
// pushes expected error pulses, a monitor pops them and tracks the error state.
module tb_nvme_pchk_arb;

    localparam int NR  = 4;
    localparam int W   = 128;
    localparam int BPP = 8;
    localparam int PW  = (W + BPP - 1) / BPP;
    localparam int IDW = $clog2(NR);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              oddpar, chk_enable, clr_err;
    logic              err_valid, first_valid;
    logic [IDW-1:0]    err_id, first_id;
    logic [PW-1:0]     err_bits, first_bits;
    logic [NR-1:0]     err_sticky;
    logic [15:0]       err_count;

    nvme_pchk_arb_if #(.NUM_REQ(NR), .WIDTH(W), .PWIDTH(PW)) req_if ();

    nvme_pchk_arb #(.NUM_REQ(NR), .WIDTH(W), .BITS_PER_PARITY_BIT(BPP)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_if      (req_if),
        .oddpar      (oddpar),
        .chk_enable  (chk_enable),
        .clr_err     (clr_err),
        .err_valid   (err_valid),
        .err_id      (err_id),
        .err_bits    (err_bits),
        .err_sticky  (err_sticky),
        .err_count   (err_count),
        .first_valid (first_valid),
        .first_id    (first_id),
        .first_bits  (first_bits)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned    due;
        logic [IDW-1:0] id;
        logic [PW-1:0]  bits;
    } exp_t;

    exp_t          sb_q[$];
    int            checks   = 0;
    int            failures = 0;
    int unsigned   cyc      = 0;
    int            m_ptr    = 0;
    int            hist[NR];

    logic [W-1:0]  d_arr[NR];
    logic [PW-1:0] p_arr[NR];

    // Reference error state, advanced by the monitor
    logic [NR-1:0]  m_sticky;
    logic [15:0]    m_count;
    logic           m_first_v;
    logic [IDW-1:0] m_first_id, m_last_id;
    logic [PW-1:0]  m_first_bits, m_last_bits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] gen_par(input logic [W-1:0] d, input logic odd);
        logic [W-1:0] sh;
        gen_par = '0;
        for (int g = 0; g < PW; g++) begin
            sh = d >> (g * BPP);
            gen_par[g] = odd ^ (($countones(sh[BPP-1:0]) % 2) == 1);
        end
    endfunction

    task automatic clear_model();
        m_sticky     = '0;
        m_count      = '0;
        m_first_v    = 1'b0;
        m_first_id   = '0;
        m_first_bits = '0;
    endtask

    // One cycle of stimulus: drive at negedge, predict the grant and any resulting error.
    task automatic drive_cycle(input logic [NR-1:0] v, input logic en, input logic clr);
        int            g;
        logic [NR-1:0] exp_rdy;
        logic [PW-1:0] mm;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            req_if.req_data[i*W +: W]    = d_arr[i];
            req_if.req_datap[i*PW +: PW] = p_arr[i];
        end
        req_if.req_valid = v;
        chk_enable       = en;
        clr_err          = clr;
        #1;
        g       = -1;
        exp_rdy = '0;
        for (int k = 0; k < NR; k++) begin
            if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_if.req_ready), 32'(exp_rdy));
        for (int i = 0; i < NR; i++) hist[i] += int'(req_if.req_ready[i]);
        if (g >= 0) begin
            m_ptr = (g + 1) % NR;
            mm    = gen_par(d_arr[g], oddpar) ^ p_arr[g];
            if (en && mm != '0) sb_q.push_back('{due: cyc + 2, id: IDW'(g), bits: mm});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle('0, 1'b1, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n          = 1'b0;
        req_if.req_valid = '0;
        clr_err          = 1'b0;
        sb_q.delete();
        m_ptr       = 0;
        clear_model();
        m_last_id   = '0;
        m_last_bits = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: pops the expected pulse due this edge and checks every error output.
    initial begin
        exp_t it;
        logic have, clr_s, rst_s;
        forever begin
            @(posedge clk);
            cyc++;
            clr_s = clr_err;
            rst_s = reset_n;
            have  = 1'b0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                it   = sb_q.pop_front();
                have = 1'b1;
            end
            if (rst_s) begin
                if (clr_s) clear_model();
                if (have) begin
                    m_last_id          = it.id;
                    m_last_bits        = it.bits;
                    m_sticky[it.id]    = 1'b1;
                    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                    if (!m_first_v) begin
                        m_first_v    = 1'b1;
                        m_first_id   = it.id;
                        m_first_bits = it.bits;
                    end
                end
            end
            #1;
            check("err_valid",   32'(err_valid),   32'(have && rst_s));
            check("err_id",      32'(err_id),      32'(m_last_id));
            check("err_bits",    32'(err_bits),    32'(m_last_bits));
            check("err_sticky",  32'(err_sticky),  32'(m_sticky));
            check("err_count",   32'(err_count),   32'(m_count));
            check("first_valid", 32'(first_valid), 32'(m_first_v));
            check("first_id",    32'(first_id),    32'(m_first_id));
            check("first_bits",  32'(first_bits),  32'(m_first_bits));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        reset_n          = 1'b0;
        oddpar           = 1'b0;
        chk_enable       = 1'b1;
        clr_err          = 1'b0;
        req_if.req_valid = '0;
        req_if.req_data  = '0;
        req_if.req_datap = '0;
        for (int i = 0; i < NR; i++) begin
            d_arr[i] = '0;
            p_arr[i] = '0;
            hist[i]  = 0;
        end
        clear_model();
        m_last_id   = '0;
        m_last_bits = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Idle after reset: no grants, all outputs quiet
        idle(10);

        // Even parity, req2 single bad parity bit in group 3
        d_arr[2] = '0;
        p_arr[2] = 16'h0008;
        drive_cycle(4'b0100, 1'b1, 1'b0);
        idle(4);

        // Reset lands while an erroring beat sits in stage 1
        d_arr[1] = '0;
        p_arr[1] = 16'h0001;
        drive_cycle(4'b0010, 1'b1, 1'b0);
        apply_reset();
        idle(3);

        // All requesters valid for 8 cycles starting from ptr 0
        for (int i = 0; i < NR; i++) begin
            d_arr[i] = {$urandom, $urandom, $urandom, $urandom};
            p_arr[i] = gen_par(d_arr[i], 1'b0);
            hist[i]  = 0;
        end
        repeat (8) drive_cycle('1, 1'b1, 1'b0);
        for (int i = 0; i < NR; i++) check($sformatf("grants_req%0d", i), 32'(hist[i]), 32'd2);
        idle(4);

        // Odd parity: matching beat, then a mismatching beat with checking disabled
        oddpar   = 1'b1;
        d_arr[0] = 128'h1;
        p_arr[0] = 16'hFFFE;
        drive_cycle(4'b0001, 1'b1, 1'b0);
        idle(2);
        p_arr[0] = 16'hFFFF;
        drive_cycle(4'b0001, 1'b0, 1'b0);
        idle(4);
        oddpar = 1'b0;
        idle(2);

        // First-error capture, then clear colliding with a req0 error
        drive_cycle('0, 1'b1, 1'b1);
        d_arr[1] = '0; p_arr[1] = 16'h0002;
        d_arr[3] = '0; p_arr[3] = 16'h0010;
        drive_cycle(4'b0010, 1'b1, 1'b0);
        drive_cycle(4'b1000, 1'b1, 1'b0);
        idle(3);
        d_arr[0] = '0; p_arr[0] = 16'h0100;
        drive_cycle(4'b0001, 1'b1, 1'b0);
        drive_cycle('0, 1'b1, 1'b1);
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                d_arr[i] = {$urandom, $urandom, $urandom, $urandom};
                p_arr[i] = gen_par(d_arr[i], oddpar) ^ (($urandom % 3 == 0) ? PW'($urandom) : '0);
            end
            drive_cycle(NR'($urandom), ($urandom % 4) != 0, ($urandom % 16) == 0);
        end
        idle(4);

        // Saturation: sustained back-to-back errors past 0xFFFF
        drive_cycle('0, 1'b1, 1'b1);
        for (int i = 0; i < NR; i++) begin
            d_arr[i] = '0;
            p_arr[i] = PW'(i + 1);
        end
        repeat (65540) drive_cycle('1, 1'b1, 1'b0);
        idle(4);
        check("count_saturated", 32'(err_count), 32'h0000FFFF);

        idle(4);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
